// File: rtl/wb_arb_pkg.sv
// Shared types and status codes for the writeback port arbiter.
// Holds the pending multdiv entry layout and the hazard-match helper.
package wb_arb_pkg;

  localparam logic [31:0] RS_ADD_OVF  = 32'd1;
  localparam logic [31:0] RS_ADDI_OVF = 32'd2;
  localparam logic [31:0] RS_SUB_OVF  = 32'd3;
  localparam logic [31:0] RS_MUL_OVF  = 32'd4;
  localparam logic [31:0] RS_DIV_ZERO = 32'd5;

  typedef struct packed {
    logic        pv;
    logic [4:0]  preg;
    logic [31:0] pdata;
    logic        pexc;
    logic [31:0] pcode;
    logic        pkill;
  } pend_entry_t;

  // A killed entry no longer writes its register, so it cannot be a hazard.
  function automatic logic hz_match(input pend_entry_t pend, input logic [4:0] src);
    return pend.pv && !pend.pkill && (pend.preg != 5'd0) && (src == pend.preg);
  endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bus bundle between the W stage / multdiv producers and the port arbiter.
// master = producer/consumer side, slave = the arbiter itself.
interface wb_port_arbiter_if;

  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        wb_exc;
  logic [31:0] wb_code;

  logic        md_valid;
  logic        md_ready;
  logic [4:0]  md_reg;
  logic [31:0] md_data;
  logic        md_exc;
  logic [31:0] md_code;

  logic        pipe_stall;
  logic [4:0]  hz_reg_a;
  logic [4:0]  hz_reg_b;
  logic        hz_a;
  logic        hz_b;

  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic        rs_write;
  logic [31:0] rs_writeData;

  modport master (
    output wb_valid, wb_reg, wb_data, wb_exc, wb_code,
    output md_valid, md_reg, md_data, md_exc, md_code,
    output hz_reg_a, hz_reg_b,
    input  md_ready, pipe_stall, hz_a, hz_b,
    input  ctrl_writeEnable, ctrl_writeReg, data_writeReg, rs_write, rs_writeData
  );

  modport slave (
    input  wb_valid, wb_reg, wb_data, wb_exc, wb_code,
    input  md_valid, md_reg, md_data, md_exc, md_code,
    input  hz_reg_a, hz_reg_b,
    output md_ready, pipe_stall, hz_a, hz_b,
    output ctrl_writeEnable, ctrl_writeReg, data_writeReg, rs_write, rs_writeData
  );

endinterface

// File: rtl/wb_starve_counter.sv
// Counts cycles a pending multdiv result is held and raises a one-cycle
// pipe_stall at STARVE_LIMIT. Only instantiated under WB_ARB_STARVE_EN.
module wb_starve_counter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input  logic clock,
  input  logic ctrl_reset,
  input  logic i_pv,
  input  logic i_grant_md,
  output logic o_pipe_stall
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             r_stall;

  assign w_cnt_inc = r_cnt + CNT_W'(1);

  // The stall cycle always grants md, which clears the count, so the stall is one cycle wide.
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      r_cnt   <= '0;
      r_stall <= 1'b0;
    end else if (!i_pv || i_grant_md) begin
      r_cnt   <= '0;
      r_stall <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_inc;
      r_stall <= (w_cnt_inc == CNT_W'(STARVE_LIMIT));
    end
  end

  assign o_pipe_stall = r_stall;

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the regfile write port and $rstatus port between W stage and multdiv.
// Define WB_ARB_STARVE_EN to enable the starvation counter and forced drain.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input logic               clock,
  input logic               ctrl_reset,
  wb_port_arbiter_if.slave  bus
);

  pend_entry_t r_pend;
  logic        w_pipe_stall;
  logic        w_grant_wb;
  logic        w_grant_md;
  logic        w_md_ready;
  logic        w_accept;
  logic        w_waw;

`ifdef WB_ARB_STARVE_EN
  wb_starve_counter #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_W        (CNT_W)
  ) u_starve (
    .clock        (clock),
    .ctrl_reset   (ctrl_reset),
    .i_pv         (r_pend.pv),
    .i_grant_md   (w_grant_md),
    .o_pipe_stall (w_pipe_stall)
  );
`else
  logic [CNT_W-1:0] w_unused_limit;
  assign w_unused_limit = CNT_W'(STARVE_LIMIT);
  assign w_pipe_stall   = 1'b0;
`endif

  assign w_grant_wb = !ctrl_reset && bus.wb_valid && !w_pipe_stall;
  assign w_grant_md = !ctrl_reset && r_pend.pv && (!bus.wb_valid || w_pipe_stall);
  assign w_md_ready = !ctrl_reset && (!r_pend.pv || w_grant_md);
  assign w_accept   = bus.md_valid && w_md_ready;
  assign w_waw      = w_grant_wb && r_pend.pv && (r_pend.preg != 5'd0) &&
                      (bus.wb_reg == r_pend.preg);

  // Accept can coincide with a drain but never with a WAW kill (kill needs a wb grant).
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      r_pend.pv    <= 1'b0;
      r_pend.pkill <= 1'b0;
    end else if (w_accept) begin
      r_pend <= '{pv: 1'b1, preg: bus.md_reg, pdata: bus.md_data,
                  pexc: bus.md_exc, pcode: bus.md_code, pkill: 1'b0};
    end else if (w_grant_md) begin
      r_pend.pv    <= 1'b0;
      r_pend.pkill <= 1'b0;
    end else if (w_waw) begin
      r_pend.pkill <= 1'b1;
    end
  end

  always_comb begin
    bus.ctrl_writeEnable = 1'b0;
    bus.ctrl_writeReg    = 5'd0;
    bus.data_writeReg    = 32'd0;
    bus.rs_write         = 1'b0;
    bus.rs_writeData     = 32'd0;
    if (w_grant_wb) begin
      bus.ctrl_writeEnable = (bus.wb_reg != 5'd0);
      bus.ctrl_writeReg    = bus.wb_reg;
      bus.data_writeReg    = bus.wb_data;
      bus.rs_write         = bus.wb_exc;
      bus.rs_writeData     = bus.wb_code;
    end else if (w_grant_md) begin
      bus.ctrl_writeEnable = (r_pend.preg != 5'd0) && !r_pend.pkill;
      bus.ctrl_writeReg    = r_pend.preg;
      bus.data_writeReg    = r_pend.pdata;
      bus.rs_write         = r_pend.pexc;
      bus.rs_writeData     = r_pend.pcode;
    end
  end

  assign bus.md_ready   = w_md_ready;
  assign bus.pipe_stall = w_pipe_stall && !ctrl_reset;
  assign bus.hz_a       = !ctrl_reset && hz_match(r_pend, bus.hz_reg_a);
  assign bus.hz_b       = !ctrl_reset && hz_match(r_pend, bus.hz_reg_b);

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter; covers both WB_ARB_STARVE_EN builds.
module tb_wb_port_arbiter;
  import wb_arb_pkg::*;

  logic clock;
  logic ctrl_reset;
  int   n_checks;
  int   n_fail;

  wb_port_arbiter_if bus();

  wb_port_arbiter #(.STARVE_LIMIT(4), .CNT_W(4)) dut (
    .clock      (clock),
    .ctrl_reset (ctrl_reset),
    .bus        (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_port(input string tag, input logic we, input logic [4:0] rg,
                          input logic [31:0] dat, input logic rsw, input logic [31:0] rsd);
    check({tag, ".we"},   32'(bus.ctrl_writeEnable), 32'(we));
    check({tag, ".reg"},  32'(bus.ctrl_writeReg),    32'(rg));
    check({tag, ".data"}, bus.data_writeReg,         dat);
    check({tag, ".rsw"},  32'(bus.rs_write),         32'(rsw));
    check({tag, ".rsd"},  bus.rs_writeData,          rsd);
  endtask

  task automatic offer_md(input logic [4:0] rg, input logic [31:0] dat,
                          input logic exc, input logic [31:0] code);
    bus.md_valid = 1'b1;
    bus.md_reg   = rg;
    bus.md_data  = dat;
    bus.md_exc   = exc;
    bus.md_code  = code;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    ctrl_reset   = 1'b1;
    bus.wb_valid = 1'b0; bus.wb_reg = 5'd0; bus.wb_data = 32'd0;
    bus.wb_exc   = 1'b0; bus.wb_code = 32'd0;
    bus.md_valid = 1'b1; bus.md_reg = 5'd2; bus.md_data = 32'd0;
    bus.md_exc   = 1'b0; bus.md_code = 32'd0;
    bus.hz_reg_a = 5'd0; bus.hz_reg_b = 5'd0;
    #1;
    check("rst.md_ready", 32'(bus.md_ready), 32'd0);
    chk_port("rst.port", 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
    tick();
    tick();
    bus.md_valid = 1'b0;
    ctrl_reset   = 1'b0;
    #1;
    check("rel.md_ready", 32'(bus.md_ready), 32'd1);
    check("rel.stall", 32'(bus.pipe_stall), 32'd0);
    chk_port("rel.idle", 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);

    // idle drain
    offer_md(5'd7, 32'h1234_5678, 1'b0, 32'd0);
    #1;
    check("idle.ready0", 32'(bus.md_ready), 32'd1);
    tick();
    bus.md_valid = 1'b0;
    #1;
    check("idle.ready1", 32'(bus.md_ready), 32'd1);
    chk_port("idle.drain", 1'b1, 5'd7, 32'h1234_5678, 1'b0, 32'd0);
    tick();
    chk_port("idle.after", 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);

    // divide-by-zero drain
    offer_md(5'd3, 32'h0000_AAAA, 1'b1, RS_DIV_ZERO);
    tick();
    bus.md_valid = 1'b0;
    #1;
    chk_port("div0", 1'b1, 5'd3, 32'h0000_AAAA, 1'b1, 32'd5);
    tick();

    // WAW kill
    offer_md(5'd9, 32'h0000_BEEF, 1'b1, RS_MUL_OVF);
    tick();
    bus.md_valid = 1'b0;
    bus.hz_reg_a = 5'd9;
    bus.hz_reg_b = 5'd1;
    bus.wb_valid = 1'b1; bus.wb_reg = 5'd9; bus.wb_data = 32'h0000_1111;
    #1;
    check("waw.hz_a0", 32'(bus.hz_a), 32'd1);
    check("waw.hz_b0", 32'(bus.hz_b), 32'd0);
    check("waw.ready", 32'(bus.md_ready), 32'd0);
    chk_port("waw.wb", 1'b1, 5'd9, 32'h0000_1111, 1'b0, 32'd0);
    tick();
    bus.wb_reg = 5'd5; bus.wb_data = 32'h0000_2222;
    #1;
    check("waw.hz_a1", 32'(bus.hz_a), 32'd0);
    chk_port("waw.wb2", 1'b1, 5'd5, 32'h0000_2222, 1'b0, 32'd0);
    tick();
    bus.wb_valid = 1'b0;
    #1;
    chk_port("waw.drain", 1'b0, 5'd9, 32'h0000_BEEF, 1'b1, 32'd4);
    tick();
    check("waw.hz_a2", 32'(bus.hz_a), 32'd0);

    // starvation
    offer_md(5'd12, 32'h0000_CAFE, 1'b0, 32'd0);
    bus.hz_reg_a = 5'd12;
    tick();
    bus.md_valid = 1'b0;
    bus.wb_valid = 1'b1; bus.wb_reg = 5'd4;
    for (int k = 0; k < 4; k++) begin
      bus.wb_data = 32'h100 + 32'(k);
      #1;
      check("starve.wait.stall", 32'(bus.pipe_stall), 32'd0);
      check("starve.wait.reg", 32'(bus.ctrl_writeReg), 32'd4);
      check("starve.wait.hz", 32'(bus.hz_a), 32'd1);
      tick();
    end
    bus.wb_data = 32'h0000_0200;
`ifdef WB_ARB_STARVE_EN
    #1;
    check("starve.stall", 32'(bus.pipe_stall), 32'd1);
    check("starve.ready", 32'(bus.md_ready), 32'd1);
    chk_port("starve.md", 1'b1, 5'd12, 32'h0000_CAFE, 1'b0, 32'd0);
    tick();
    check("starve.stall_off", 32'(bus.pipe_stall), 32'd0);
    chk_port("starve.wb", 1'b1, 5'd4, 32'h0000_0200, 1'b0, 32'd0);
    tick();
`else
    #1;
    check("hold.stall", 32'(bus.pipe_stall), 32'd0);
    chk_port("hold.wb", 1'b1, 5'd4, 32'h0000_0200, 1'b0, 32'd0);
    tick();
    bus.wb_valid = 1'b0;
    #1;
    chk_port("hold.md", 1'b1, 5'd12, 32'h0000_CAFE, 1'b0, 32'd0);
    tick();
`endif
    bus.wb_valid = 1'b0;
    #1;
    check("starve.hz_clr", 32'(bus.hz_a), 32'd0);

    // back-to-back accept with drain
    offer_md(5'd6, 32'd1, 1'b0, 32'd0);
    tick();
    offer_md(5'd8, 32'd2, 1'b0, 32'd0);
    #1;
    check("b2b.ready", 32'(bus.md_ready), 32'd1);
    chk_port("b2b.first", 1'b1, 5'd6, 32'd1, 1'b0, 32'd0);
    tick();
    bus.md_valid = 1'b0;
    #1;
    chk_port("b2b.second", 1'b1, 5'd8, 32'd2, 1'b0, 32'd0);
    tick();

    // r0 write from pipeline, exception still reaches $rstatus
    bus.wb_valid = 1'b1; bus.wb_reg = 5'd0; bus.wb_data = 32'h0000_FFFF;
    bus.wb_exc = 1'b1; bus.wb_code = RS_ADD_OVF;
    #1;
    chk_port("r0", 1'b0, 5'd0, 32'h0000_FFFF, 1'b1, 32'd1);
    tick();
    bus.wb_valid = 1'b0; bus.wb_exc = 1'b0; bus.wb_code = 32'd0;

    // reset while an entry is pending
    offer_md(5'd10, 32'h0000_0055, 1'b1, RS_SUB_OVF);
    bus.hz_reg_b = 5'd10;
    tick();
    bus.md_valid = 1'b0;
    #1;
    check("rstp.hz_b", 32'(bus.hz_b), 32'd1);
    ctrl_reset = 1'b1;
    #1;
    check("rstp.ready", 32'(bus.md_ready), 32'd0);
    chk_port("rstp.port", 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
    tick();
    ctrl_reset = 1'b0;
    #1;
    check("rstp.ready_rel", 32'(bus.md_ready), 32'd1);
    check("rstp.hz_b_rel", 32'(bus.hz_b), 32'd0);
    chk_port("rstp.rel", 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
    tick();
    chk_port("rstp.rel2", 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
